// File: rtl/arb_pkg.sv
// Shared types and constants for the memory arbiter and its picker.
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_READ  = 2'b01,
    ARB_WRITE = 2'b10
  } arb_state_e;

  localparam logic ARB_MODE_RR    = 1'b0;
  localparam logic ARB_MODE_FIXED = 1'b1;

endpackage

// File: rtl/rr_picker.sv
// Combinational N-way request picker: round-robin from a start pointer,
// or fixed priority (lowest index wins) when mode selects it.
module rr_picker
  import arb_pkg::*;
#(
  parameter  int N     = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start_ptr,
  input  logic             mode,
  output logic [N-1:0]     grant_onehot,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W-1:0] base_s;
  logic [IDX_W:0]   cand_s;

  // Walk the request vector from the base index, wrapping modulo N.
  always_comb begin
    grant_onehot = {N{1'b0}};
    grant_idx    = {IDX_W{1'b0}};
    grant_valid  = 1'b0;
    cand_s       = {(IDX_W+1){1'b0}};
    if (mode == ARB_MODE_FIXED) begin
      base_s = {IDX_W{1'b0}};
    end else begin
      base_s = start_ptr;
    end
    for (int i = 0; i < N; i++) begin
      cand_s = {1'b0, base_s} + (IDX_W+1)'(i);
      if (cand_s >= (IDX_W+1)'(N)) begin
        cand_s = cand_s - (IDX_W+1)'(N);
      end else begin
        cand_s = cand_s;
      end
      if (!grant_valid && req[cand_s[IDX_W-1:0]]) begin
        grant_valid                          = 1'b1;
        grant_idx                            = cand_s[IDX_W-1:0];
        grant_onehot[cand_s[IDX_W-1:0]]      = 1'b1;
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-to-1 arbiter sharing one memory between several masters, one
// transaction at a time, with registered downstream request outputs.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter  int NUM_MASTERS = 2,
  parameter  int ADDR_WIDTH  = 32,
  parameter  int DATA_WIDTH  = 32,
  parameter  int ARB_MODE    = 0,
  localparam int STRB_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  m_address      [NUM_MASTERS],
  input  logic [NUM_MASTERS-1:0] m_read_enable,
  output logic [DATA_WIDTH-1:0]  m_read_data    [NUM_MASTERS],
  output logic [NUM_MASTERS-1:0] m_read_valid,
  input  logic [NUM_MASTERS-1:0] m_write_enable,
  input  logic [DATA_WIDTH-1:0]  m_write_data   [NUM_MASTERS],
  input  logic [STRB_WIDTH-1:0]  m_write_wstrb  [NUM_MASTERS],
  output logic [NUM_MASTERS-1:0] m_write_ready,
  output logic [ADDR_WIDTH-1:0]  mem_address,
  output logic                   mem_read_enable,
  input  logic [DATA_WIDTH-1:0]  mem_read_data,
  input  logic                   mem_read_valid,
  output logic                   mem_write_enable,
  output logic [DATA_WIDTH-1:0]  mem_write_data,
  output logic [STRB_WIDTH-1:0]  mem_write_wstrb,
  input  logic                   mem_write_ready
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  arb_state_e             state_r;
  logic [IDX_W-1:0]       grant_r;
  logic [IDX_W-1:0]       rr_ptr_r;
  logic [NUM_MASTERS-1:0] req_s;
  logic [NUM_MASTERS-1:0] pick_onehot_s;
  logic [IDX_W-1:0]       pick_idx_s;
  logic                   pick_valid_s;
  logic                   mode_s;
  logic                   pick_write_s;

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(NUM_MASTERS - 1)) begin
      return {IDX_W{1'b0}};
    end else begin
      return idx + IDX_W'(1);
    end
  endfunction

  assign mode_s = (ARB_MODE == 1) ? ARB_MODE_FIXED : ARB_MODE_RR;
  assign req_s  = m_read_enable | m_write_enable;

  rr_picker #(
    .N (NUM_MASTERS)
  ) u_picker (
    .req          (req_s),
    .start_ptr    (rr_ptr_r),
    .mode         (mode_s),
    .grant_onehot (pick_onehot_s),
    .grant_idx    (pick_idx_s),
    .grant_valid  (pick_valid_s)
  );

  // A master asserting both read and write gets its write served first.
  assign pick_write_s = |(pick_onehot_s & m_write_enable);

  // Transaction FSM with latched downstream request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r          <= ARB_IDLE;
      grant_r          <= {IDX_W{1'b0}};
      rr_ptr_r         <= {IDX_W{1'b0}};
      mem_address      <= {ADDR_WIDTH{1'b0}};
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_write_data   <= {DATA_WIDTH{1'b0}};
      mem_write_wstrb  <= {STRB_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (pick_valid_s) begin
            grant_r         <= pick_idx_s;
            mem_address     <= m_address[pick_idx_s];
            mem_write_data  <= m_write_data[pick_idx_s];
            mem_write_wstrb <= m_write_wstrb[pick_idx_s];
            if (pick_write_s) begin
              mem_write_enable <= 1'b1;
              state_r          <= ARB_WRITE;
            end else begin
              mem_read_enable <= 1'b1;
              state_r         <= ARB_READ;
            end
          end
        end
        ARB_READ: begin
          if (mem_read_valid) begin
            mem_read_enable <= 1'b0;
            rr_ptr_r        <= next_ptr(grant_r);
            state_r         <= ARB_IDLE;
          end
        end
        ARB_WRITE: begin
          if (mem_write_ready) begin
            mem_write_enable <= 1'b0;
            rr_ptr_r         <= next_ptr(grant_r);
            state_r          <= ARB_IDLE;
          end
        end
        default: begin
          mem_read_enable  <= 1'b0;
          mem_write_enable <= 1'b0;
          state_r          <= ARB_IDLE;
        end
      endcase
    end
  end

  // Read data is broadcast; only the granted master sees a valid pulse.
  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_read_data[i] = mem_read_data;
    end
  end

  // Completion pass-through, gated by state and grant.
  always_comb begin
    m_read_valid  = {NUM_MASTERS{1'b0}};
    m_write_ready = {NUM_MASTERS{1'b0}};
    if (reset) begin
      m_read_valid  = {NUM_MASTERS{1'b0}};
      m_write_ready = {NUM_MASTERS{1'b0}};
    end else if (state_r == ARB_READ) begin
      m_read_valid[grant_r] = mem_read_valid;
    end else if (state_r == ARB_WRITE) begin
      m_write_ready[grant_r] = mem_write_ready;
    end else begin
      m_read_valid  = {NUM_MASTERS{1'b0}};
      m_write_ready = {NUM_MASTERS{1'b0}};
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised N-to-1 arbiter placing several memory masters (core data port, instruction fetch, DMA or debug) onto one `memory` instance using the codebase's existing request/valid handshake (`read_enable`/`read_valid`, `write_enable`/`write_wstrb`/`write_ready`). It replaces the fixed one-memory-per-port wiring in the top level, so a single unified memory can serve all masters. It serves one transaction at a time, with round-robin or fixed-priority selection, and uses registered downstream request outputs.

## Interface
- `NUM_MASTERS`, default 2: number of upstream ports, ≥2.
- `ADDR_WIDTH`, default 32: address width.
- `DATA_WIDTH`, default 32: data width, multiple of 8; strobe width `STRB_WIDTH = DATA_WIDTH/8`.
- `ARB_MODE`, default 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `m_address` in `[NUM_MASTERS][ADDR_WIDTH]`: per-master address.
- `m_read_enable` in `[NUM_MASTERS]`: read request, held until `m_read_valid`.
- `m_read_data` out `[NUM_MASTERS][DATA_WIDTH]`: read data; `mem_read_data` broadcast to every master.
- `m_read_valid` out `[NUM_MASTERS]`: one-cycle read completion pulse, granted master only.
- `m_write_enable` in `[NUM_MASTERS]`: write request, held until `m_write_ready`.
- `m_write_data` in `[NUM_MASTERS][DATA_WIDTH]`: write data.
- `m_write_wstrb` in `[NUM_MASTERS][STRB_WIDTH]`: byte strobes.
- `m_write_ready` out `[NUM_MASTERS]`: one-cycle write completion pulse, granted master only.
- `mem_address` out `ADDR_WIDTH`: address to memory.
- `mem_read_enable` out 1: read request to memory.
- `mem_read_data` in `DATA_WIDTH`: read data from memory.
- `mem_read_valid` in 1: read completion from memory.
- `mem_write_enable` out 1: write request to memory.
- `mem_write_data` out `DATA_WIDTH`: write data to memory.
- `mem_write_wstrb` out `STRB_WIDTH`: byte strobes to memory.
- `mem_write_ready` in 1: write completion from memory.

## Operation
- Master *i* is requesting when `m_read_enable[i] | m_write_enable[i]`.
- FSM states:
  - IDLE: if any request, latch winner index `grant`, op type, address, wdata and wstrb → READ or WRITE.
  - READ: wait for `mem_read_valid`, then → IDLE.
  - WRITE: wait for `mem_write_ready`, then → IDLE.
- Same master asserting read and write together: write is served first. The read stays pending and competes again in IDLE.
- Round-robin: search starts at `rr_ptr`, wrapping modulo `NUM_MASTERS`. On completion `rr_ptr <= grant+1`, wrapping from `NUM_MASTERS-1` to 0. Fixed mode ignores `rr_ptr`.
- Downstream outputs come only from latched registers. Master inputs changing mid-transaction have no effect.
- Completion in READ/WRITE: `m_read_valid[grant]` / `m_write_ready[grant]` = `mem_read_valid` / `mem_write_ready` in the same cycle. This is a combinational pass-through gated by state and grant; all other masters see 0.
- Completion inputs arriving in IDLE, or of the wrong type for the current state, are ignored.
- Reset values: state IDLE, `rr_ptr` 0, `mem_read_enable` 0, `mem_write_enable` 0, `mem_address`/`mem_write_data`/`mem_write_wstrb` 0, all `m_read_valid` and `m_write_ready` 0.
- Reset mid-transaction: IDLE at the next edge and enables drop. The memory must tolerate an abandoned request.

## Timing
- Request first seen in IDLE at cycle t → `mem_*_enable` high from t+1 and held until the completion cycle c inclusive. Enable is low at c+1.
- Upstream completion pulse appears in cycle c, with zero added response latency.
- Masters deassert or change their request at c+1. IDLE re-arbitrates at c+1, so the minimum occupancy is memory latency + 2 cycles per transaction.
- Memory asserting completion in the same cycle as the enable (c = t+1) is legal.
- No combinational path from `m_*` inputs to `mem_*` outputs.

## Structure
- `arb_pkg`: state enum (`ARB_IDLE`, `ARB_READ`, `ARB_WRITE`) and `ARB_MODE_RR` / `ARB_MODE_FIXED` constants.
- Sub-module `rr_picker`: combinational N-way picker. Inputs: request vector, start pointer, mode. Outputs: one-hot grant and encoded index. Reused by future interconnect blocks.

## Test plan
- Single master read, memory latency 1: `m_read_enable[0]` with addr 0x100 at t → `mem_read_enable` at t+1; `mem_read_valid` with data 0xDEADBEEF at t+2 → `m_read_valid[0]`=1 and data 0xDEADBEEF at t+2; `mem_read_enable` low at t+3.
- Round-robin, NUM_MASTERS=3: all three read continuously → grant order 0,1,2,0,1,2; no master served twice before the others.
- Fixed priority, ARB_MODE=1: masters 0 and 1 request continuously → master 0 always granted; master 1 is served only after master 0 drops its request.
- Write with strobe: master 1 writes 0x11223344 with wstrb 4'b0101 to 0x200 → memory sees the same data, strobe and address; `m_write_ready[1]` pulses once; `m_write_ready[0]` stays 0.
- Simultaneous read and write from master 0: write is issued first; after `write_ready`, the read is issued in the next transaction.
- Reset asserted during READ before `mem_read_valid` → the next cycle shows IDLE, all enables 0, `rr_ptr` 0; a late `mem_read_valid` produces no upstream pulse.
